// File: rtl/mips_defs_pkg.sv
// Shared MIPS multicycle definitions: FSM state codes, primary opcodes and
// ALUOp encodings, used by the main control and by downstream ALU control.
package mips_defs_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for every opcode the control FSM knows how to sequence.
    function automatic logic isKnownOp(input logic [5:0] op);
        logic known;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: known = 1'b1;
            default:                                   known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode for the multicycle control FSM; only FETCH looks at
// memReady, so IR/PC load exactly when the instruction fetch completes.
module control_decode
    import mips_defs_pkg::*;
(
    input  logic [3:0] state,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);

    // Per-state strobes; anything not named for a state stays low.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = memReady;
                PCWrite = memReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: state register, next-state logic and a sticky
// illegal-opcode flag; datapath strobes come from control_decode.
module multicycle_control
    import mips_defs_pkg::*;
#(
    parameter logic MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    logic [3:0] state_r;
    logic [3:0] nextState_s;
    logic       illegalOp_r;
    logic       memReady_s;
    logic       decodeIllegal_s;

    assign memReady_s      = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign decodeIllegal_s = (state_r == S_DECODE) && !isKnownOp(opcode);

    // Next-state selection; MEMADR re-examines the live opcode to pick read or write.
    always_comb begin
        nextState_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (memReady_s) nextState_s = S_DECODE;
                else            nextState_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         nextState_s = S_EXEC;
                    OP_LW, OP_SW: nextState_s = S_MEMADR;
                    OP_BEQ:       nextState_s = S_BRANCH;
                    OP_J:         nextState_s = S_JUMP;
                    OP_ADDI:      nextState_s = S_ADDIEX;
                    default:      nextState_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW)      nextState_s = S_MEMWR;
                else if (opcode == OP_LW) nextState_s = S_MEMRD;
                else                      nextState_s = S_FETCH;
            end
            S_MEMRD: begin
                if (memReady_s) nextState_s = S_MEMWB;
                else            nextState_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (memReady_s) nextState_s = S_FETCH;
                else            nextState_s = S_MEMWR;
            end
            S_EXEC:   nextState_s = S_ALUWB;
            S_ADDIEX: nextState_s = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: nextState_s = S_FETCH;
            default:  nextState_s = S_FETCH;
        endcase
    end

    // State register and sticky illegal flag; only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_FETCH;
            illegalOp_r <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if (decodeIllegal_s) illegalOp_r <= 1'b1;
            else                 illegalOp_r <= illegalOp_r;
        end
    end

    assign state      = state_r;
    assign illegal_op = illegalOp_r;

    control_decode uDecode (
        .state       (state_r),
        .memReady    (memReady_s),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares state plus the full control word per cycle.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       illegal_op;

    int passCnt  = 0;
    int totalCnt = 0;

    // Control word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    // RegWrite,RegDst,ALUSrcA,PCSource[1:0],ALUSrcB[1:0],ALUOp[1:0]
    logic [15:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp};

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .state       (state),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived control words per state.
    function automatic logic [15:0] expCtrl(input logic [3:0] st, input logic mr);
        case (st)
            4'd0:    expCtrl = mr ? 16'b1001_0100_0000_0100 : 16'b0001_0000_0000_0100;
            4'd1:    expCtrl = 16'b0000_0000_0000_1100;
            4'd2:    expCtrl = 16'b0000_0000_0100_1000;
            4'd3:    expCtrl = 16'b0011_0000_0000_0000;
            4'd4:    expCtrl = 16'b0000_0011_0000_0000;
            4'd5:    expCtrl = 16'b0010_1000_0000_0000;
            4'd6:    expCtrl = 16'b0000_0000_0100_0010;
            4'd7:    expCtrl = 16'b0000_0001_1000_0000;
            4'd8:    expCtrl = 16'b0100_0000_0101_0001;
            4'd9:    expCtrl = 16'b1000_0000_0010_0000;
            4'd10:   expCtrl = 16'b0000_0000_0100_1000;
            4'd11:   expCtrl = 16'b0000_0001_0000_0000;
            default: expCtrl = 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b000000; mem_ready = 1'b0;
        #12;
        totalCnt++;
        if (state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state);
        else passCnt++;
        totalCnt++;
        if (ctrl !== expCtrl(4'd0, 1'b0)) $display("FAIL reset_ctrl got=%b exp=%b", ctrl, expCtrl(4'd0, 1'b0));
        else passCnt++;
        totalCnt++;
        if (illegal_op !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal_op);
        else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        // FETCH must hold while memory is not ready.
        tick();
        totalCnt++;
        if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0)
            $display("FAIL fetch_hold state=%0d IRWrite=%b PCWrite=%b exp=0/0/0", state, IRWrite, PCWrite);
        else passCnt++;
        mem_ready = 1'b1;
        #1;
        totalCnt++;
        if (ctrl !== expCtrl(4'd0, 1'b1)) $display("FAIL fetch_ready_ctrl got=%b exp=%b", ctrl, expCtrl(4'd0, 1'b1));
        else passCnt++;
    endtask

    // Runs from FETCH with mem_ready=1 and checks each visited state.
    task automatic test_lw();
        logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            totalCnt++;
            if (state !== seq[i]) $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, state, seq[i]);
            else passCnt++;
            totalCnt++;
            if (ctrl !== expCtrl(seq[i], 1'b1)) $display("FAIL lw_ctrl step=%0d got=%b exp=%b", i, ctrl, expCtrl(seq[i], 1'b1));
            else passCnt++;
            totalCnt++;
            if ((MemtoReg & RegWrite) !== (seq[i] == 4'd4)) $display("FAIL lw_wb step=%0d got=%b", i, MemtoReg & RegWrite);
            else passCnt++;
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0] seq [7] = '{4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        opcode = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            mem_ready = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            #1;
            totalCnt++;
            if (state !== seq[i]) $display("FAIL sw_state step=%0d got=%0d exp=%0d", i, state, seq[i]);
            else passCnt++;
            totalCnt++;
            if (ctrl !== expCtrl(seq[i], mem_ready)) $display("FAIL sw_ctrl step=%0d got=%b exp=%b", i, ctrl, expCtrl(seq[i], mem_ready));
            else passCnt++;
            totalCnt++;
            if ((MemRead & MemWrite) !== 1'b0) $display("FAIL sw_rw_excl step=%0d got=1 exp=0", i);
            else passCnt++;
        end
        mem_ready = 1'b1;
    endtask

    // Generic short-sequence instruction (R-type, addi, beq, j).
    task automatic test_alu_branch(input string name, input logic [5:0] op,
                                   input logic [3:0] s1, input logic [3:0] s2,
                                   input logic [3:0] s3, input int n);
        logic [3:0] seq [4];
        seq[0] = 4'd1; seq[1] = s1; seq[2] = s2; seq[3] = s3;
        opcode = op; mem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            // Opcode changes after DECODE must not disturb the sequence.
            if (i == 1) opcode = 6'b100011;
            totalCnt++;
            if (state !== seq[i]) $display("FAIL %s_state step=%0d got=%0d exp=%0d", name, i, state, seq[i]);
            else passCnt++;
            totalCnt++;
            if (ctrl !== expCtrl(seq[i], 1'b1)) $display("FAIL %s_ctrl step=%0d got=%b exp=%b", name, i, ctrl, expCtrl(seq[i], 1'b1));
            else passCnt++;
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        tick();
        totalCnt++;
        if (state !== 4'd1 || illegal_op !== 1'b0) $display("FAIL ill_decode state=%0d illegal=%b exp=1/0", state, illegal_op);
        else passCnt++;
        tick();
        totalCnt++;
        if (state !== 4'd0 || illegal_op !== 1'b1) $display("FAIL ill_set state=%0d illegal=%b exp=0/1", state, illegal_op);
        else passCnt++;
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) tick();
        totalCnt++;
        if (state !== 4'd0 || illegal_op !== 1'b1) $display("FAIL ill_sticky state=%0d illegal=%b exp=0/1", state, illegal_op);
        else passCnt++;
        #2;
        rst_n = 1'b0;
        #1;
        totalCnt++;
        if (illegal_op !== 1'b0) $display("FAIL ill_clear got=%b exp=0", illegal_op);
        else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        opcode = 6'b100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        totalCnt++;
        if (state !== 4'd3) $display("FAIL ar_memrd got=%0d exp=3", state);
        else passCnt++;
        #2;
        rst_n = 1'b0;
        #1;
        totalCnt++;
        if (state !== 4'd0) $display("FAIL ar_async got=%0d exp=0", state);
        else passCnt++;
        totalCnt++;
        if (ctrl !== expCtrl(4'd0, 1'b1)) $display("FAIL ar_ctrl got=%b exp=%b", ctrl, expCtrl(4'd0, 1'b1));
        else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        totalCnt++;
        if (state !== 4'd1) $display("FAIL ar_restart got=%0d exp=1", state);
        else passCnt++;
        tick(); tick(); tick(); tick();
        totalCnt++;
        if (state !== 4'd0) $display("FAIL ar_finish got=%0d exp=0", state);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_branch("rtype", 6'b000000, 4'd6, 4'd7, 4'd0, 4);
        test_alu_branch("addi", 6'b001000, 4'd10, 4'd11, 4'd0, 4);
        test_alu_branch("beq", 6'b000100, 4'd8, 4'd0, 4'd0, 3);
        test_alu_branch("j", 6'b000010, 4'd9, 4'd0, 4'd0, 3);
        test_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1; when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst and ALUSrcA, each 1 bit: standard multicycle datapath strobes and selects.
REQ-007 SHALL have outputs PCSource (2 bits), ALUSrcB (2 bits) and ALUOp (2 bits); ALUOp encodes 00 add, 01 subtract, 10 use funct.
REQ-008 SHALL have outputs state (4 bits, debug) and illegal_op (1 bit, sticky).

Function
REQ-009 SHALL implement an FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10 and ADDIWB=11; codes 12-15 are unused.
REQ-010 SHALL take these transitions: FETCH->DECODE on mem_ready, else hold.
REQ-011 SHALL take these transitions from DECODE by opcode: 000000->EXEC; 100011 or 101011->MEMADR; 000100->BRANCH; 000010->JUMP; 001000->ADDIEX; any other opcode->FETCH.
REQ-012 SHALL take these transitions: MEMADR->MEMRD for lw, MEMADR->MEMWR for sw.
REQ-013 SHALL take these transitions: MEMRD->MEMWB on mem_ready, else hold; MEMWR->FETCH on mem_ready, else hold.
REQ-014 SHALL take these transitions: MEMWB, ALUWB, BRANCH, JUMP and ADDIWB go to FETCH; EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-015 SHALL go to FETCH on the next edge from any unused state code.
REQ-016 SHALL deassert (0) every output not listed for the current state in REQ-017..REQ-022.
REQ-017 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and IRWrite=PCWrite=mem_ready (combinational on mem_ready).
REQ-018 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00; MEMADR and ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-019 MEMRD SHALL drive MemRead=1, IorD=1; MEMWR SHALL drive MemWrite=1, IorD=1; MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; ALUWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; JUMP SHALL drive PCWrite=1, PCSource=10.
REQ-022 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0.
REQ-023 SHALL keep MemWrite and MemRead mutually exclusive in every cycle.
REQ-024 SHALL set illegal_op on the edge leaving DECODE with an unrecognised opcode; it stays 1 until reset.
REQ-025 SHALL use the opcode value sampled during DECODE for the branch; an opcode change in other states has no effect except in MEMADR, which SHALL use the current opcode.
REQ-026 SHALL give fixed cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-027 On rst_n=0, asynchronously, the FSM SHALL set state=FETCH and illegal_op=0; outputs SHALL follow FETCH decode.
REQ-028 Reset mid-instruction SHALL abandon the instruction; after rst_n rises the first edge is evaluated as FETCH.

Structure
REQ-029 The state codes, the opcode constants (R, LW, SW, BEQ, J, ADDI) and the ALUOp codes SHALL live in shared include mips_defs, which downstream ALU control also uses.
REQ-030 SHALL consist of one state register plus next-state logic; the Moore output decode MAY be a sub-module named control_decode.

Verification
REQ-031 Reset then lw (100011) with mem_ready=1 SHALL visit states 0,1,2,3,4,0; MemtoReg=RegWrite=1 only in state 4.
REQ-032 sw with mem_ready low for 3 cycles in MEMWR SHALL hold state 5 with MemWrite=1 for 4 cycles, then return to 0.
REQ-033 R-type (000000) SHALL give ALUOp=10 in EXEC, then RegDst=RegWrite=1 in ALUWB.
REQ-034 beq (000100) SHALL give ALUOp=01, PCWriteCond=1, PCSource=01 in state 8; j (000010) SHALL give PCWrite=1, PCSource=10 in state 9.
REQ-035 Opcode 111111 in DECODE SHALL go to state 0 and set illegal_op=1, which SHALL survive a following lw; rst_n low SHALL clear it.
REQ-036 rst_n asserted in MEMRD SHALL return state=0 immediately, without waiting for clk.
